// File: rtl/operand_fetch_pkg.sv
// Shared widths and state encoding for the operand fetch stage.
package operand_fetch_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FRESH = 2'd1,
    HELD  = 2'd2
  } state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for in-flight writes, with a three-way hazard lookup.
module reg_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ce,
  input  logic              i_set_en,
  input  logic [REG_AW-1:0] i_set_addr,
  input  logic              i_wb_clr_en,
  input  logic [REG_AW-1:0] i_wb_clr_addr,
  input  logic              i_fl_clr_en,
  input  logic [REG_AW-1:0] i_fl_clr_addr,
  input  logic [REG_AW-1:0] i_rs1,
  input  logic [REG_AW-1:0] i_rs2,
  input  logic [REG_AW-1:0] i_rd,
  input  logic              i_rd_we,
  output logic              o_hazard_c
);

  localparam int unsigned NREGS = 1 << REG_AW;

  logic [NREGS-1:0] busy_q, busy_d, busy_eff_c;

  // A writeback landing this cycle already counts as retired for the lookup.
  always_comb begin
    busy_eff_c = busy_q;
    if (i_wb_clr_en) begin
      busy_eff_c[i_wb_clr_addr] = 1'b0;
    end
    o_hazard_c = busy_eff_c[i_rs1] | busy_eff_c[i_rs2] | (i_rd_we & busy_eff_c[i_rd]);
  end

  // Set is applied last so it wins over a same-cycle clear.
  always_comb begin
    busy_d = busy_q;
    if (i_ce) begin
      busy_d = busy_eff_c;
      if (i_fl_clr_en) begin
        busy_d[i_fl_clr_addr] = 1'b0;
      end
      if (i_set_en) begin
        busy_d[i_set_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Decode-side operand reader: drives register-file reads, stalls on busy registers,
// forwards same-cycle writebacks and holds operands behind a valid/ready handshake.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ce,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [REG_AW-1:0] i_rs1,
  input  logic [REG_AW-1:0] i_rs2,
  input  logic [REG_AW-1:0] i_rd,
  input  logic              i_rd_we,
  output logic [REG_AW-1:0] o_addr_rd_a,
  output logic [REG_AW-1:0] o_addr_rd_b,
  input  logic [XLEN-1:0]   i_rf_dat_a,
  input  logic [XLEN-1:0]   i_rf_dat_b,
  input  logic              i_wb_we,
  input  logic [REG_AW-1:0] i_wb_addr,
  input  logic [XLEN-1:0]   i_wb_dat,
  input  logic              i_flush,
  output logic              o_op_valid,
  input  logic              i_op_ready,
  output logic [XLEN-1:0]   o_op_a,
  output logic [XLEN-1:0]   o_op_b,
  output logic [REG_AW-1:0] o_op_rd,
  output logic              o_op_rd_we
);

  state_e            state_q, state_d;
  logic              hazard_c, req_ready_c, accept_c, drop_c;
  logic [XLEN-1:0]   fresh_a_c, fresh_b_c;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              rd_we_q, rd_we_d;
  logic              byp_a_q, byp_a_d, byp_b_q, byp_b_d;
  logic [XLEN-1:0]   byp_dat_a_q, byp_dat_a_d, byp_dat_b_q, byp_dat_b_d;
  logic [XLEN-1:0]   lat_a_q, lat_a_d, lat_b_q, lat_b_d;

  assign o_addr_rd_a = i_rs1;
  assign o_addr_rd_b = i_rs2;

  assign req_ready_c = i_ce & ~i_flush & ~hazard_c & ((state_q == EMPTY) | i_op_ready);
  assign o_req_ready = req_ready_c;
  assign accept_c    = i_req_valid & req_ready_c;
  // Flush only retires the busy bit of an entry execute has not taken.
  assign drop_c      = i_flush & (state_q != EMPTY) & ~i_op_ready & rd_we_q;

  reg_scoreboard u_sb (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_ce          (i_ce),
    .i_set_en      (accept_c & i_rd_we & (i_rd != '0)),
    .i_set_addr    (i_rd),
    .i_wb_clr_en   (i_wb_we & (i_wb_addr != '0)),
    .i_wb_clr_addr (i_wb_addr),
    .i_fl_clr_en   (drop_c),
    .i_fl_clr_addr (rd_q),
    .i_rs1         (i_rs1),
    .i_rs2         (i_rs2),
    .i_rd          (i_rd),
    .i_rd_we       (i_rd_we),
    .o_hazard_c    (hazard_c)
  );

  // x0 is folded into the bypass path as a forced zero.
  assign fresh_a_c = byp_a_q ? byp_dat_a_q : i_rf_dat_a;
  assign fresh_b_c = byp_b_q ? byp_dat_b_q : i_rf_dat_b;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_ce) begin
      if (i_flush) begin
        state_d = EMPTY;
      end else begin
        case (state_q)
          EMPTY:       state_d = accept_c ? FRESH : EMPTY;
          FRESH, HELD: state_d = i_op_ready ? (accept_c ? FRESH : EMPTY) : HELD;
          default:     state_d = EMPTY;
        endcase
      end
    end
  end

  always_comb begin
    o_op_valid = (state_q != EMPTY);
    o_op_a     = lat_a_q;
    o_op_b     = lat_b_q;
    if (state_q == FRESH) begin
      o_op_a = fresh_a_c;
      o_op_b = fresh_b_c;
    end
    o_op_rd    = rd_q;
    o_op_rd_we = rd_we_q;
  end

  always_comb begin
    rd_d        = rd_q;
    rd_we_d     = rd_we_q;
    byp_a_d     = byp_a_q;
    byp_b_d     = byp_b_q;
    byp_dat_a_d = byp_dat_a_q;
    byp_dat_b_d = byp_dat_b_q;
    lat_a_d     = lat_a_q;
    lat_b_d     = lat_b_q;
    if (accept_c) begin
      rd_d        = i_rd;
      rd_we_d     = i_rd_we;
      byp_a_d     = (i_rs1 == '0) | (i_wb_we & (i_wb_addr == i_rs1));
      byp_b_d     = (i_rs2 == '0) | (i_wb_we & (i_wb_addr == i_rs2));
      byp_dat_a_d = (i_rs1 == '0) ? '0 : i_wb_dat;
      byp_dat_b_d = (i_rs2 == '0) ? '0 : i_wb_dat;
    end
    // Register-file data is only valid for one cycle; capture it if execute stalls.
    if (i_ce & (state_q == FRESH) & ~i_op_ready) begin
      lat_a_d = fresh_a_c;
      lat_b_d = fresh_b_c;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_q        <= '0;
      rd_we_q     <= 1'b0;
      byp_a_q     <= 1'b0;
      byp_b_q     <= 1'b0;
      byp_dat_a_q <= '0;
      byp_dat_b_q <= '0;
      lat_a_q     <= '0;
      lat_b_q     <= '0;
    end else begin
      rd_q        <= rd_d;
      rd_we_q     <= rd_we_d;
      byp_a_q     <= byp_a_d;
      byp_b_q     <= byp_b_d;
      byp_dat_a_q <= byp_dat_a_d;
      byp_dat_b_q <= byp_dat_b_d;
      lat_a_q     <= lat_a_d;
      lat_b_q     <= lat_b_d;
    end
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode-side reader for the synchronous-read register file `regs`. The register file returns read data one cycle after the address and never reflects a same-cycle write.
- Accepts operand requests and drives the register-file read addresses.
- Keeps a per-register busy scoreboard for in-flight writes and stalls on RAW/WAW hazards.
- Bypasses same-cycle writebacks and holds the operands stable behind a valid/ready handshake to execute.

Parameters:
- XLEN, 32, data width; must match the register-file data width.
- REG_AW, 5, register address width; 2**REG_AW registers, x0 hardwired zero.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_ce  in  1  clock enable; when low, no state changes
- i_req_valid  in  1  decode has an operand request
- o_req_ready  out  1  request accepted this cycle when high with i_req_valid
- i_rs1, i_rs2  in  REG_AW  source register indices
- i_rd  in  REG_AW  destination index
- i_rd_we  in  1  request will write i_rd
- o_addr_rd_a, o_addr_rd_b  out  REG_AW  to the register-file read ports; equal to i_rs1/i_rs2 combinationally
- i_rf_dat_a, i_rf_dat_b  in  XLEN  register-file read data, valid the cycle after the address
- i_wb_we, i_wb_addr, i_wb_dat  in  1/REG_AW/XLEN  mirror of the register-file write port
- i_flush  in  1  drop the entry not yet taken by execute
- o_op_valid  out  1  operands valid
- i_op_ready  in  1  execute takes operands
- o_op_a, o_op_b  out  XLEN  operand values
- o_op_rd, o_op_rd_we  out  REG_AW/1  pass-through of the destination

Behaviour:
- Reset (async, i_rst=1):
  - state=EMPTY, scoreboard=0.
  - o_op_valid=0; o_op_a, o_op_b, o_op_rd, o_op_rd_we all 0.
  - Latched operands=0.
- States:
  - EMPTY: no entry held.
  - FRESH: cycle after accept; operands come from i_rf_dat with bypass applied.
  - HELD: operands come from local latches.
- Hazard condition: hazard = busy[i_rs1] | busy[i_rs2] | (i_rd_we & busy[i_rd]).
  - busy[0] is always 0.
  - A busy bit being cleared by a writeback in the same cycle counts as not busy.
- o_req_ready = i_ce & !i_flush & !hazard & (state==EMPTY | i_op_ready).
- Accept (cycle T): if i_rd_we and i_rd!=0, set busy[i_rd].
  - Record the request's rd/rd_we.
  - Record the bypass flags byp_a = i_wb_we & i_wb_addr==i_rs1 & i_rs1!=0, with the matching data; same for b.
  - Next state is FRESH.
- Operand values:
  - FRESH (T+1): o_op_a = rs1==0 ? 0 : (byp_a ? captured wb data : i_rf_dat_a); same for b.
  - Leaving FRESH with !i_op_ready latches these values and moves to HELD.
- Transitions:
  - FRESH or HELD with i_op_ready: a new accept goes to FRESH, otherwise to EMPTY.
  - EMPTY with no accept stays EMPTY.
  - Back-to-back accepts give one operand set per cycle, latency 1.
- o_op_valid = state!=EMPTY.
- Writeback: i_ce & i_wb_we & i_wb_addr!=0 clears busy[i_wb_addr].
  - If the same cycle's accept sets the same bit, set wins.
- Flush:
  - State goes to EMPTY.
  - The busy bit set by the dropped entry (if rd_we and rd!=0) is cleared.
  - No accept happens that cycle.
  - Busy bits of instructions already in execute are untouched.
- i_ce=0: state, latches and scoreboard are frozen. Outputs keep their values, except that the FRESH-state outputs follow i_rf_dat, which is also frozen by the register file under ce.
- Reset mid-operation: the held entry is lost and every busy bit is cleared; the upstream pipeline is reset with it.

Decomposition:
- Shared package (or config include): XLEN, REG_AW, and state encodings EMPTY=2'd0, FRESH=2'd1, HELD=2'd2.
- One natural sub-module, `reg_scoreboard`:
  - Holds the busy vector.
  - Provides the set port (accept) and the clear ports (writeback, flush).
  - Exposes the 3-way busy lookup.
- operand_fetch instantiates reg_scoreboard plus the FSM and bypass logic.

Test Plan:
1. Reset, then request rs1=1, rs2=2, rd=3, rd_we=1, with the rf returning 0x11 and 0x22. The next cycle gives o_op_valid=1, a=0x11, b=0x22, and busy[3]=1.
2. With busy[3] set, request rs1=3. o_req_ready=0 until writeback addr=3 data=0xABCD arrives. In that same cycle the request is accepted with the rf returning stale 0, and the next cycle gives a=0xABCD through the bypass.
3. Request rs1=0, rs2=0 with the rf driving 0xFFFFFFFF. Operands are 0/0; a writeback to addr 0 changes no busy bit.
4. Accept with i_op_ready=0 for 3 cycles while i_rf_dat changes to 0xDEAD. o_op_a stays at the original value (HELD). Raising i_op_ready then completes the transfer.
5. Accept rd=5 and hold, then assert i_flush. Next cycle o_op_valid=0, busy[5]=0, and a request reading x5 is accepted immediately.
6. Assert i_rst asynchronously mid-FRESH with busy bits set. Outputs go to 0 at once, the scoreboard clears, and state is EMPTY on the first clock after release.
